// File: rtl/i2s_in_pkg.sv
// Shared constants and types for the I2S receive path.
package i2s_in_pkg;

    localparam int unsigned SAMPLE_W = 16;
    localparam int unsigned FRAME_W  = 2 * SAMPLE_W;
    localparam int unsigned FIFO_AW  = 3;
    // Counter only needs 0..SAMPLE_W-1; completion is detected on the last bit.
    localparam int unsigned CNT_W    = $clog2(SAMPLE_W);

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StWaitL = 2'd1,
        StShift = 2'd2,
        StHold  = 2'd3
    } des_state_e;

endpackage

// File: rtl/i2s_in_if.sv
// Frame handshake between the I2S receiver (master) and the filter (slave).
interface i2s_in_if;

    logic                             i2si_filt_rts;
    logic                             filt_i2si_rtr;
    logic [i2s_in_pkg::FRAME_W-1:0]   i2si_filt_data;

    modport master (
        output i2si_filt_rts,
        output i2si_filt_data,
        input  filt_i2si_rtr
    );

    modport slave (
        input  i2si_filt_rts,
        input  i2si_filt_data,
        output filt_i2si_rtr
    );

endinterface

// File: rtl/i2s_in_deserializer.sv
// I2S slot deserializer: tracks WS edges, shifts SD MSB-first and emits one push per L/R pair.
module i2s_in_deserializer
    import i2s_in_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               sck_transition,
    input  logic               ws,
    input  logic               sd,
    input  logic               en,
    output logic               push,
    output logic [FRAME_W-1:0] frame
);

    des_state_e          state, state_nx;
    logic                ws_prev;
    logic [CNT_W-1:0]    bit_cnt, bit_cnt_nx;
    logic [SAMPLE_W-1:0] shift_reg, shift_nx;
    logic [SAMPLE_W-1:0] left_reg, left_nx;
    logic [SAMPLE_W-1:0] right_reg, right_nx;
    logic                left_valid, left_valid_nx;
    logic                push_nx;
    logic                ws_edge;
    logic                last_bit;
    logic [SAMPLE_W-1:0] word;

    assign ws_edge  = sck_transition & (ws ^ ws_prev);
    assign last_bit = (bit_cnt == CNT_W'(SAMPLE_W - 1));
    assign word     = {shift_reg[SAMPLE_W-2:0], sd};
    assign frame    = {left_reg, right_reg};

    // WS history, sampled on every SCK pulse regardless of state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ws_prev <= 1'b0;
        else if (sck_transition) ws_prev <= ws;
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= StIdle;
            bit_cnt    <= '0;
            shift_reg  <= '0;
            left_reg   <= '0;
            right_reg  <= '0;
            left_valid <= 1'b0;
            push       <= 1'b0;
        end else begin
            state      <= state_nx;
            bit_cnt    <= bit_cnt_nx;
            shift_reg  <= shift_nx;
            left_reg   <= left_nx;
            right_reg  <= right_nx;
            left_valid <= left_valid_nx;
            push       <= push_nx;
        end
    end

    // Next-state: the pulse that reveals a WS edge still carries the previous slot's LSB,
    // so a slot completes on the edge pulse itself when slots are exactly SAMPLE_W long.
    always_comb begin
        state_nx      = state;
        bit_cnt_nx    = bit_cnt;
        shift_nx      = shift_reg;
        left_nx       = left_reg;
        right_nx      = right_reg;
        left_valid_nx = left_valid;
        push_nx       = 1'b0;
        if (!en) begin
            state_nx      = StIdle;
            bit_cnt_nx    = '0;
            left_valid_nx = 1'b0;
        end else begin
            unique case (state)
                StIdle: begin
                    state_nx      = StWaitL;
                    bit_cnt_nx    = '0;
                    left_valid_nx = 1'b0;
                end
                StWaitL: begin
                    if (ws_edge && !ws) begin
                        state_nx   = StShift;
                        bit_cnt_nx = '0;
                    end
                end
                StShift: begin
                    if (sck_transition) begin
                        shift_nx   = word;
                        bit_cnt_nx = bit_cnt + CNT_W'(1);
                        if (last_bit) begin
                            state_nx = StHold;
                            // ws_prev is still the channel of the slot being completed.
                            if (!ws_prev) begin
                                left_nx       = word;
                                left_valid_nx = 1'b1;
                            end else begin
                                right_nx      = word;
                                push_nx       = left_valid;
                                left_valid_nx = 1'b0;
                            end
                        end else if (ws_edge && !ws_prev) begin
                            // Short left slot: its pair can no longer form a frame.
                            left_valid_nx = 1'b0;
                        end
                        if (ws_edge) begin
                            state_nx   = StShift;
                            bit_cnt_nx = '0;
                        end
                    end
                end
                StHold: begin
                    if (ws_edge) begin
                        state_nx   = StShift;
                        bit_cnt_nx = '0;
                    end
                end
                default: state_nx = StIdle;
            endcase
        end
    end

endmodule

// File: rtl/sync_fifo.sv
// Shared single-clock FIFO; a write while full is accepted only if a read frees space.
module sync_fifo #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned AW    = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);

    localparam int unsigned DEPTH = 1 << AW;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_wr;
    logic             do_rd;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_rd   = rd_en & ~empty;
    assign do_wr   = wr_en & (~full | do_rd);
    // Head entry is presented combinationally; zero while empty so reset data reads 0.
    assign rd_data = empty ? '0 : mem[rd_ptr[AW-1:0]];

    // Pointer update.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + 1'b1;
            if (do_rd) rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Storage write; contents need no reset since reads are gated by empty.
    always_ff @(posedge clk) begin
        if (do_wr) mem[wr_ptr[AW-1:0]] <= wr_data;
    end

endmodule

// File: rtl/i2s_in.sv
// I2S receive path top: deserializer, 8-deep frame FIFO and sticky overrun/underrun flags.
module i2s_in
    import i2s_in_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       sck_transition,
    input  logic       i2si_ws,
    input  logic       i2si_sd,
    input  logic       rf_i2si_en,
    i2s_in_if.master   filt,
    input  logic       trig_fifo_overrun,
    input  logic       trig_fifo_underrun,
    output logic       ro_fifo_overrun,
    output logic       ro_fifo_underrun
);

    logic               push;
    logic [FRAME_W-1:0] frame;
    logic               full;
    logic               empty;
    logic               pop;
    logic               overrun_nx;
    logic               underrun_nx;

    assign filt.i2si_filt_rts = ~empty;
    assign pop                = filt.i2si_filt_rts & filt.filt_i2si_rtr;

    i2s_in_deserializer u_deser (
        .clk            (clk),
        .rst_n          (rst_n),
        .sck_transition (sck_transition),
        .ws             (i2si_ws),
        .sd             (i2si_sd),
        .en             (rf_i2si_en),
        .push           (push),
        .frame          (frame)
    );

    sync_fifo #(
        .WIDTH (FRAME_W),
        .AW    (FIFO_AW)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (push),
        .wr_data (frame),
        .rd_en   (pop),
        .rd_data (filt.i2si_filt_data),
        .full    (full),
        .empty   (empty)
    );

    // Sticky flags: a set condition beats a same-cycle clear trigger.
    always_comb begin
        overrun_nx  = (push & full & ~pop) | (ro_fifo_overrun & ~trig_fifo_overrun);
        underrun_nx = (filt.filt_i2si_rtr & ~filt.i2si_filt_rts)
                    | (ro_fifo_underrun & ~trig_fifo_underrun);
    end

    // Flag registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ro_fifo_overrun  <= 1'b0;
            ro_fifo_underrun <= 1'b0;
        end else begin
            ro_fifo_overrun  <= overrun_nx;
            ro_fifo_underrun <= underrun_nx;
        end
    end

endmodule
